seq_divider: RTL
================

# seq_divider

Multicycle signed 32-bit integer divider implementing MIPS DIV semantics for the CPU datapath. Sits beside the multiplier, upstream of the HI/LO select muxes: the control FSM pulses a start, reads operands straight from register-bank outputs A/B, waits for completion, then HI/LO capture remainder/quotient. Restoring algorithm, one quotient bit per cycle, with a divide-by-zero flag consumed by the exception path.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported by the CPU.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- div_start  in  1  start request; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (register A); sampled on the accepting edge only.
- divisor  in  WIDTH  signed divisor (register B); sampled on the accepting edge only.
- div_end  out  1  one-cycle completion pulse.
- hi  out  WIDTH  remainder; registered; holds until the next successful completion.
- lo  out  WIDTH  quotient; registered; holds until the next successful completion.
- div_by_zero  out  1  divisor was zero; registered, sticky until the next accepted start.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + div_start=1, divisor!=0: latch |dividend| into the quotient shift register, |divisor| into the divisor register, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend); clear the 33-bit partial remainder and the 6-bit count; clear div_by_zero; go to RUN.
- IDLE + div_start=1, divisor==0: set div_by_zero=1; pulse div_end on the next cycle; hi/lo unchanged; stay IDLE.
- RUN, per cycle: shift {rem, quot} left by 1; trial = rem - divisor; if trial is non-negative, rem = trial and quot[0]=1, else quot[0]=0; count++. After the 32nd iteration (count==31 before increment), go to FIX.
- FIX: lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem. Quotient truncates toward zero; remainder takes the dividend's sign. Assert div_end; go to IDLE.
- Magnitudes are 32-bit unsigned, so |0x80000000| = 2^31 and is exact.
- Overflow case 0x80000000 / -1 gives lo=0x80000000, hi=0. No overflow flag.
- div_start is ignored in RUN and in FIX. There is no abort.
- Operand changes after the accepting edge have no effect.

## Timing
- E0 is the edge on which start is accepted. Iterations occur on E1..E32. On E33 hi/lo load, div_end rises, and the state returns to IDLE.
- div_end is high for exactly one cycle (E33 to E34). Latency is 33 cycles from start to result valid.
- Earliest next accept is E34. Sustained throughput is one division per 34 cycles.
- Zero-divisor path: div_by_zero and div_end both rise on E0+1 (div_end combined with the zero-check register, or registered from IDLE), so both are observed one edge after the start. div_end stays high for one cycle. div_by_zero stays high until the next accepted start.
- Reset (any time, including mid-RUN): state=IDLE, hi=0, lo=0, div_end=0, div_by_zero=0, count=0, internal registers=0. The first start after deassertion behaves normally.
- div_start held high continuously: a new division is accepted every 34 cycles. It is never re-accepted during RUN or FIX.

## Structure
- Package div_pkg holds:
  - the state enum typedef (IDLE/RUN/FIX),
  - DIV_WIDTH=32,
  - DIV_CNT_W=6,
  - DIV_ITERS=32.
- One natural sub-module: div_step, a combinational restoring iteration. Input: {rem, quot, divisor}. Output: next {rem, quot}. It is instantiated once in the sequential wrapper.
- Sign fix-up (two's-complement negation) stays inline in FIX.

## Test plan
- 100 / 7 → div_end at E33, lo=14, hi=2; div_by_zero=0.
- -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7 / -2 → lo=-3, hi=1. Also -7 / -2 → lo=3, hi=-1.
- Zero divisor: prior result hi=2, lo=14, then start 5 / 0 → div_by_zero=1 and a single-cycle div_end one edge later; hi=2, lo=14 unchanged. A following 9 / 3 clears the flag and gives lo=3, hi=0.
- Extremes:
  - 0x80000000 / -1 → lo=0x80000000, hi=0.
  - 0x80000000 / 1 → lo=0x80000000, hi=0.
  - 0x7FFFFFFF / 0x7FFFFFFF → lo=1, hi=0.
- Start re-pulsed and operands changed during RUN → ignored; the original result and 33-cycle latency are preserved. Next accept at E34 works.
- Async reset asserted mid-RUN (iteration 10), between edges → all outputs 0 immediately. After release, 100 / 7 completes correctly at 33 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the multicycle signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the
// divisor, and keep the difference only when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_nxt,
    output logic [W-1:0] quot_nxt
);

    // One extra bit above the shifted remainder acts as the borrow/sign of the trial.
    logic [W+1:0] rem_sh;
    logic [W+1:0] trial;

    always_comb begin
        rem_sh = {rem, quot[W-1]};
        trial  = rem_sh - {2'b00, divisor};
        if (!trial[W+1]) begin
            rem_nxt  = trial[W:0];
            quot_nxt = {quot[W-2:0], 1'b1};
        end else begin
            rem_nxt  = rem_sh[W:0];
            quot_nxt = {quot[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Signed 32-bit MIPS DIV unit: lo = quotient (truncated toward zero), hi = remainder
// (dividend's sign). Handshake: div_start is a level request sampled only in IDLE;
// div_end is a one-cycle completion pulse with no back-pressure.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_end,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output div_state_e       dbg_state
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_ITERS - 1);

    div_state_e           state;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     dvsr;
    logic [DIV_CNT_W-1:0] count;
    logic                 sign_q;
    logic                 sign_r;

    logic [WIDTH:0]       rem_nxt;
    logic [WIDTH-1:0]     quot_nxt;
    logic [WIDTH-1:0]     dividend_mag;
    logic [WIDTH-1:0]     divisor_mag;

    // Unsigned magnitudes: |0x80000000| wraps to itself, which is exactly 2^31.
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

    div_step #(.W(WIDTH)) u_step (
        .rem      (rem),
        .quot     (quot),
        .divisor  (dvsr),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            quot        <= '0;
            dvsr        <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_end     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            // Results are left untouched; only the flag and done pulse fire.
                            div_by_zero <= 1'b1;
                            div_end     <= 1'b1;
                        end else begin
                            quot        <= dividend_mag;
                            dvsr        <= divisor_mag;
                            sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r      <= dividend[WIDTH-1];
                            rem         <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    quot  <= quot_nxt;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo      <= sign_q ? -quot : quot;
                    hi      <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_end <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
